// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: instruction field widths, opcode values
// and the fetch FSM state encoding.
package fetch_unit_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_W   = 3;
  localparam int IMM_W   = 5;

  localparam logic [OPC_W-1:0] OP_R   = 3'b000;
  localparam logic [OPC_W-1:0] OP_LI  = 3'b001;
  localparam logic [OPC_W-1:0] OP_LD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_ST  = 3'b011;
  localparam logic [OPC_W-1:0] OP_CMP = 3'b100;
  localparam logic [OPC_W-1:0] OP_J   = 3'b101;
  localparam logic [OPC_W-1:0] OP_JC  = 3'b110;
  localparam logic [OPC_W-1:0] OP_JCN = 3'b111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and imem (slave).
interface fetch_unit_if #(
  parameter int ADDR_W = 8
);
  import fetch_unit_pkg::*;

  // Handshake: imem_req rises with a valid imem_addr and stays high (address
  // stable) until the slave returns a single-cycle imem_ack carrying imem_rdata.
  // An imem_ack while imem_req is low carries no transfer and is ignored.
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_branch_resolve.sv
// Branch decision: unconditional J, or JC taken when the equality test
// (optionally inverted by NEQ) holds.
module branch_resolve (
  input  logic j,
  input  logic jc,
  input  logic neq,
  input  logic eq_flag,
  output logic taken
);

  assign taken = j | (jc & (eq_flag ^ neq));

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC and IR, sequences imem reads, waits for execution, then
// advances or branches. Define FETCH_TIMEOUT_EN to add the WAIT watchdog and HALT.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  fetch_unit_if.master       imem,
  output logic [OPC_W-1:0]   OPCode,
  output logic [IMM_W-1:0]   imm,
  output logic               instr_valid,
  input  logic               J,
  input  logic               JC,
  input  logic               NEQ,
  input  logic               eq_flag,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               exec_done,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_err,
  output fetch_state_t       state_dbg
);

  fetch_state_t       state;
  logic [INSTR_W-1:0] ir;
  logic               req;
  logic               taken;

  branch_resolve u_branch (
    .j       (J),
    .jc      (JC),
    .neq     (NEQ),
    .eq_flag (eq_flag),
    .taken   (taken)
  );

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc;
  assign OPCode         = ir[INSTR_W-1 -: OPC_W];
  assign imm            = ir[IMM_W-1:0];
  assign state_dbg      = state;

`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd;
  logic            err;

  assign fetch_err = err;
`else
  // The limit only matters when the watchdog is built in.
  assign fetch_err = 1'b0 & (TIMEOUT_CYC != 0);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      req         <= 1'b0;
      instr_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wd          <= '0;
      err         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state <= FETCH;
            req   <= 1'b1;
          end
        end
        FETCH: begin
`ifdef FETCH_TIMEOUT_EN
          wd <= '0;
`endif
          // A zero-latency ack lands here and skips WAIT entirely.
          if (imem.imem_ack) begin
            ir          <= imem.imem_rdata;
            req         <= 1'b0;
            instr_valid <= 1'b1;
            state       <= DECODE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_ack) begin
            ir          <= imem.imem_rdata;
            req         <= 1'b0;
            instr_valid <= 1'b1;
            state       <= DECODE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wd == WD_LAST) begin
            req   <= 1'b0;
            err   <= 1'b1;
            state <= HALT;
          end else begin
            wd <= wd + WD_W'(1);
          end
`endif
        end
        DECODE: begin
          state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            pc          <= taken ? jump_target : pc + ADDR_W'(1);
            instr_valid <= 1'b0;
            if (run) begin
              state <= FETCH;
              req   <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
`ifdef FETCH_TIMEOUT_EN
        HALT: begin
          state <= HALT;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver tasks play imem and control unit,
// a monitor pops expected addresses, instruction bytes and PCs as they appear.
`timescale 1ns/1ps
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int ADDR_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- DUT ----------------
  logic              j = 1'b0, jc = 1'b0, neq = 1'b0, eq_flag = 1'b0, exec_done = 1'b0;
  logic [ADDR_W-1:0] jump_target = '0;
  logic [2:0]        opcode;
  logic [4:0]        imm;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc;
  logic              fetch_err;
  fetch_state_t      state_dbg;

  fetch_unit_if #(.ADDR_W(ADDR_W)) imem_if ();

  fetch_unit #(
    .ADDR_W      (ADDR_W),
    .RESET_PC    (8'h00),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem        (imem_if),
    .OPCode      (opcode),
    .imm         (imm),
    .instr_valid (instr_valid),
    .J           (j),
    .JC          (jc),
    .NEQ         (neq),
    .eq_flag     (eq_flag),
    .jump_target (jump_target),
    .exec_done   (exec_done),
    .pc          (pc),
    .fetch_err   (fetch_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_ir_q[$];
  logic [7:0] exp_pc_q[$];
  logic [7:0] model_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whenever the DUT presents a new request, instruction or PC.
  logic req_q = 1'b0, iv_q = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      req_q = 1'b0;
      iv_q  = 1'b0;
    end else begin
      if (imem_if.imem_req && !req_q) begin
        if (exp_addr_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
        else chk("imem_addr", 32'(imem_if.imem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (instr_valid && !iv_q) begin
        if (exp_ir_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else chk("instr_fields", 32'({opcode, imm}), 32'(exp_ir_q.pop_front()));
        chk("fetch_err_clear", 32'(fetch_err), 32'd0);
      end
      if (!instr_valid && iv_q) begin
        if (exp_pc_q.size() == 0) chk("unexpected_retire", 32'd1, 32'd0);
        else chk("pc_update", 32'(pc), 32'(exp_pc_q.pop_front()));
      end
      req_q = imem_if.imem_req;
      iv_q  = instr_valid;
    end
  end

  // ---------------- driver tasks ----------------
  // One instruction: ack after lat cycles, exec_done after exec_lat EXEC cycles.
  task automatic do_instr(input int lat, input logic [7:0] instr, input int exec_lat,
                          input logic tj, input logic tjc, input logic tneq, input logic teq,
                          input logic [7:0] tgt, input logic run_after, output int t_req);
    int  budget;
    bit  tk;
    budget = 0;
    while (!imem_if.imem_req && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    t_req = cyc;
    if (!imem_if.imem_req) begin
      chk("req_wait_timeout", 32'd0, 32'd1);
      return;
    end
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      exec_done   = (k == 0 && lat >= 2);
      j           = (k == 0 && lat >= 2);
      jump_target = 8'hAA;
    end
    exec_done = 1'b0;
    j         = 1'b0;
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = instr;
    exp_ir_q.push_back(instr);
    @(negedge clk);
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 8'($urandom);
    @(negedge clk);
    if (!run_after) run = 1'b0;
    for (int k = 0; k < exec_lat; k++) begin
      imem_if.imem_ack   = (k == 0);
      imem_if.imem_rdata = 8'($urandom);
      @(negedge clk);
      imem_if.imem_ack = 1'b0;
    end
    chk("ir_hold", 32'({opcode, imm}), 32'(instr));
    j = tj; jc = tjc; neq = tneq; eq_flag = teq; jump_target = tgt;
    exec_done = 1'b1;
    if (tj)       tk = 1'b1;
    else if (tjc) tk = tneq ? !teq : teq;
    else          tk = 1'b0;
    model_pc = tk ? tgt : 8'((int'(model_pc) + 1) % 256);
    exp_pc_q.push_back(model_pc);
    exp_addr_q.push_back(model_pc);
    @(negedge clk);
    exec_done = 1'b0; j = 1'b0; jc = 1'b0; neq = 1'b0; eq_flag = 1'b0;
    if (!run_after) begin
      chk("idle_after_run_drop", 32'(state_dbg), 32'(IDLE));
      repeat (3) @(negedge clk);
      chk("idle_no_req", 32'(imem_if.imem_req), 32'd0);
      run = 1'b1;
    end
  endtask

  task automatic wait_req();
    int budget;
    budget = 0;
    while (!imem_if.imem_req && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!imem_if.imem_req) chk("req_wait_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    int t0, t1, tdummy;
    imem_if.imem_ack   = 1'b0;
    imem_if.imem_rdata = 8'h00;
    rst_n = 1'b0;
    run   = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_pc", 32'(pc), 32'h00);
    chk("reset_req", 32'(imem_if.imem_req), 32'd0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));
    chk("reset_err", 32'(fetch_err), 32'd0);
    model_pc = 8'h00;
    exp_addr_q.push_back(8'h00);
    rst_n = 1'b1;

    // sequential fetch, then 4-cycle instruction period
    do_instr(1, 8'hC5, 0, 0, 0, 0, 0, 8'h00, 1'b1, t0);
    do_instr(1, 8'h22, 0, 1, 0, 0, 0, 8'h40, 1'b1, t1);
    chk("cycles_per_instr", 32'(t1 - t0), 32'd4);

    // conditional branches and J-over-JC priority
    do_instr(1, 8'h61, 0, 0, 1, 0, 1, 8'h40, 1'b1, tdummy);
    do_instr(0, 8'h73, 1, 0, 1, 1, 1, 8'h40, 1'b1, tdummy);
    do_instr(2, 8'hE4, 0, 0, 1, 1, 0, 8'h40, 1'b1, tdummy);
    do_instr(1, 8'hA9, 0, 1, 1, 0, 0, 8'h77, 1'b1, tdummy);

    // wrap from 8'hFF to 8'h00
    do_instr(1, 8'h1F, 0, 1, 0, 0, 0, 8'hFF, 1'b1, tdummy);
    do_instr(1, 8'h05, 0, 0, 0, 0, 0, 8'h12, 1'b1, tdummy);

    // run dropped during EXEC
    do_instr(3, 8'h3C, 2, 0, 0, 0, 0, 8'h00, 1'b0, tdummy);

    // reset while a fetch is outstanding
    wait_req();
    @(negedge clk);
    chk("wait_req_high", 32'(imem_if.imem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_reset_req", 32'(imem_if.imem_req), 32'd0);
    chk("midop_reset_pc", 32'(pc), 32'h00);
    chk("midop_reset_state", 32'(state_dbg), 32'(IDLE));
    exp_addr_q.delete();
    exp_ir_q.delete();
    exp_pc_q.delete();
    model_pc = 8'h00;
    exp_addr_q.push_back(8'h00);
    rst_n = 1'b1;

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      do_instr($urandom_range(0, 3), 8'($urandom), $urandom_range(0, 3),
               1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom), 1'($urandom_range(0, 7) != 0), tdummy);
    end

`ifdef FETCH_TIMEOUT_EN
    wait_req();
    repeat (15) @(negedge clk);
    chk("wd_boundary_err", 32'(fetch_err), 32'd0);
    chk("wd_boundary_req", 32'(imem_if.imem_req), 32'd1);
    @(negedge clk);
    chk("timeout_err", 32'(fetch_err), 32'd1);
    chk("timeout_req", 32'(imem_if.imem_req), 32'd0);
    chk("timeout_state", 32'(state_dbg), 32'(HALT));
    imem_if.imem_ack   = 1'b1;
    imem_if.imem_rdata = 8'h99;
    @(negedge clk);
    imem_if.imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("late_ack_ignored_state", 32'(state_dbg), 32'(HALT));
    chk("late_ack_ignored_valid", 32'(instr_valid), 32'd0);
    chk("halt_err_sticky", 32'(fetch_err), 32'd1);
`else
    do_instr(40, 8'h5A, 0, 0, 0, 0, 0, 8'h00, 1'b1, tdummy);
    do_instr(1, 8'hB7, 1, 0, 0, 0, 0, 8'h00, 1'b1, tdummy);
    chk("no_watchdog_err", 32'(fetch_err), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
